// File: rtl/memory_unit.sv
// memory_unit -- memory stage of the pipeline.
//
// Holds one instruction from execute, decodes it and, for a live load/store,
// runs a single data-memory access (IDLE -> ACCESS -> IDLE). While the access
// waits for mem_ack the upstream is stalled. A 16-cycle watchdog abandons a
// request that never acks and raises a sticky error.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   instr_in      instruction from execute ([31:28] cond, [27:21] opcode, [15:12] rd)
//   branch_in     branch tag travelling with instr_in
//   branch_ref    current branch tag; mismatching held instructions are dead
//   sel_stall     downstream stall, blocks capture only
//   mem_ack       completion of the outstanding request
//   instr_output  held instruction to writeback
//   rd, rd_valid  held destination and liveness for forwarding
//   branch_value  held branch tag
//   mem_req/mem_we data memory request and direction (1 = store)
//   stall_out     upstream stall while an access is pending
//   ldr_wb_en     one-cycle pulse after a load completes
//   mem_err       sticky timeout flag
module memory_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        branch_in,
  input  logic        branch_ref,
  input  logic        sel_stall,
  input  logic        mem_ack,
  output logic [31:0] instr_output,
  output logic [3:0]  rd,
  output logic        rd_valid,
  output logic        branch_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic        stall_out,
  output logic        ldr_wb_en,
  output logic        mem_err
);

  localparam logic S_IDLE   = 1'b0;
  localparam logic S_ACCESS = 1'b1;
  localparam logic [3:0] WAIT_MAX = 4'd15;

  logic        state;
  logic [3:0]  wait_cnt;
  logic [31:0] instr_q;
  logic        branch_q;

  logic        advance;
  logic        in_bubble, in_mem_op, start;
  logic        q_bubble, q_load;

  // Decode of the incoming instruction, used only at capture.
  assign in_bubble = (instr_in[31:28] == 4'hF) || (instr_in == 32'h0);
  assign in_mem_op = (instr_in[27:26] == 2'b11) || (instr_in[27:25] == 3'b100);
  assign start     = advance && !in_bubble && in_mem_op && (branch_in == branch_ref);

  // Decode of the held instruction.
  assign q_bubble = (instr_q[31:28] == 4'hF) || (instr_q == 32'h0);
  assign q_load   = (instr_q[27:25] == 3'b100) || instr_q[21];

  assign mem_req   = (state == S_ACCESS);
  assign mem_we    = mem_req && !q_load;
  assign stall_out = mem_req && !mem_ack;
  assign advance   = !sel_stall && !stall_out;

  assign instr_output = instr_q;
  assign rd           = instr_q[15:12];
  assign branch_value = branch_q;
  assign rd_valid     = !q_bubble && (branch_q == branch_ref);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      instr_q   <= 32'h0;
      branch_q  <= 1'b0;
      ldr_wb_en <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      ldr_wb_en <= 1'b0;
      if (advance) begin
        instr_q  <= instr_in;
        branch_q <= branch_in;
      end
      case (state)
        S_IDLE: begin
          // mem_ack here belongs to nobody and is ignored.
          if (start) begin
            state    <= S_ACCESS;
            wait_cnt <= 4'd0;
          end
        end
        default: begin
          if (mem_ack) begin
            // Ack wins over timeout; the next op may start at the same edge.
            ldr_wb_en <= q_load;
            state     <= start ? S_ACCESS : S_IDLE;
            wait_cnt  <= 4'd0;
          end else if (wait_cnt == WAIT_MAX) begin
            state   <= S_IDLE;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 instr_in  in  32  instruction from the execute stage; [31:28] cond, [27:21] opcode[6:0], [15:12] rd.
REQ-004 branch_in  in  1  branch tag accompanying instr_in.
REQ-005 branch_ref  in  1  current branch tag; a held instruction whose tag differs is squashed.
REQ-006 sel_stall  in  1  downstream stall; high freezes the stage register.
REQ-007 mem_ack  in  1  data memory completion for the outstanding request.
REQ-008 instr_output  out  32  held instruction, forwarded to writeback.
REQ-009 rd  out  4  held rd, used by execute-stage forwarding.
REQ-010 rd_valid  out  1  held instruction is live (not bubble, not squashed).
REQ-011 branch_value  out  1  held branch tag.
REQ-012 mem_req  out  1  data memory request.
REQ-013 mem_we  out  1  1 = store, 0 = load; meaningful only while mem_req=1.
REQ-014 stall_out  out  1  upstream stall while an access is pending.
REQ-015 ldr_wb_en  out  1  one-cycle pulse after a successful load completes.
REQ-016 mem_err  out  1  sticky timeout flag.

Function
REQ-017 Decode: a memory op is opcode[6:5]==2'b11 or opcode[6:4]==3'b100. It is a load if opcode[6:4]==3'b100 or opcode[0]==1; otherwise it is a store.
REQ-018 Bubble: cond==4'b1111 or instr==32'h0 is a bubble; a bubble never requests memory and has rd_valid=0.
REQ-019 Advance: advance = !sel_stall && !stall_out. On advance the stage captures instr_in and branch_in; otherwise the register holds.
REQ-020 FSM states: IDLE and ACCESS.
REQ-021 IDLE -> ACCESS on an advance edge that captures a non-bubble memory op with branch_in==branch_ref; all other captures stay in IDLE.
REQ-022 In ACCESS: mem_req=1 and mem_we=!load. The first mem_req cycle is the cycle immediately after the capture edge.
REQ-023 stall_out = (state==ACCESS) && !mem_ack, combinational. On the ack cycle the next instruction may be captured at the same edge (zero-bubble back-to-back accesses).
REQ-024 ACCESS -> IDLE on an edge where mem_ack=1. If the op is a load, ldr_wb_en=1 for exactly the following cycle.
REQ-025 Wait counter: 4-bit, cleared on entry to ACCESS, incremented each ACCESS cycle without ack.
REQ-026 Timeout: if the counter equals 15 and mem_ack=0, the FSM goes to IDLE at that edge, mem_err is set, and ldr_wb_en is not pulsed. The ACCESS dwell is therefore 16 cycles maximum.
REQ-027 Ack precedence: mem_ack on the counter==15 cycle counts as success; no error is flagged.
REQ-028 mem_ack while in IDLE is ignored.
REQ-029 Squash timing: the squash check applies only at capture. A request once issued completes normally, even if branch_ref changes during ACCESS.
REQ-030 rd_valid = held non-bubble && branch_value==branch_ref, evaluated combinationally every cycle.
REQ-031 sel_stall during ACCESS does not hold mem_req off. Completion proceeds; only capture is blocked.

Reset
REQ-032 While rst=1 at an edge: state=IDLE, counter=0, instruction register=32'h0, branch_value=0, mem_err=0.
REQ-033 After that reset edge: mem_req=0, stall_out=0, ldr_wb_en=0, rd=0, rd_valid=0.
REQ-034 Reset mid-ACCESS abandons the request; mem_req drops in the cycle after the reset edge.
REQ-035 mem_err clears only on reset.

Verification
REQ-036 Load, opcode 7'b1100001, tags equal, ack on 3rd ACCESS cycle -> mem_req high 3 cycles with mem_we=0; stall_out high 2 cycles; ldr_wb_en pulses 1 cycle after ack.
REQ-037 Two stores back-to-back, ack on the first ACCESS cycle each -> mem_req stays high 2 consecutive cycles with mem_we=1; stall_out never high; ldr_wb_en=0.
REQ-038 Memory op captured with branch_in=1, branch_ref=0 -> no mem_req; rd_valid=0; stall_out=0.
REQ-039 Load with no ack -> mem_req high exactly 16 cycles, then IDLE with mem_err=1, no ldr_wb_en; mem_err persists until rst.
REQ-040 ack on the 16th ACCESS cycle -> success, mem_err=0; ack in IDLE -> no effect.
REQ-041 rst asserted on the 2nd ACCESS cycle -> all outputs at their reset values the next cycle; a following load operates normally.
